input_fifo_rx: RTL and testbench
================================

// Module: input_fifo_rx
// PURPOSE
//  Receiving end of the router RTS/DCTS link: accepts flits from an upstream
//  sender (arbiter/output port), buffers them in a small FIFO, and returns a
//  one-cycle DCTS acknowledge per accepted flit. Sits at each router input
//  port, feeding the local LBDR/arbiter stage through a read-side FIFO interface.
// PARAMETERS
//  DATA_WIDTH  32  flit width in bits
//  DEPTH       4   FIFO entries; power of 2, >= 2; pointer width = log2(DEPTH)
// PORTS
//  clk       input   1           clock, all state on rising edge
//  rst       input   1           asynchronous, active-low reset
//  RX        input   DATA_WIDTH  flit from upstream, valid while RTS=1
//  RTS       input   1           upstream request-to-send
//  DCTS      output  1           clear-to-send/ack to upstream, registered
//  read_en   input   1           consumer pops head entry this cycle
//  Data_out  output  DATA_WIDTH  head entry (show-ahead, combinational from mem)
//  empty     output  1           FIFO holds 0 entries
//  full      output  1           FIFO holds DEPTH entries
//  err       output  1           sticky read-underflow flag (see CONFIGURATION)
// BEHAVIOUR
//  Reset (rst=0, async): DCTS=0, empty=1, full=0, err=0, rd/wr ptrs=0,
//   count=0, FSM=IDLE. Memory contents not reset; Data_out undefined while empty.
//  FSM (2 states, registered):
//   IDLE: if RTS=1 && full=0 -> write RX at wr_ptr, wr_ptr++, DCTS<=1, ->ACK.
//         else DCTS<=0, stay IDLE.
//   ACK : DCTS<=0, -> IDLE unconditionally; RTS is ignored in ACK (sender
//         still holds RTS high this cycle; a flit must never be captured twice).
//  Timing: RTS high in cycle t -> flit written at edge end of t, DCTS=1 for
//   exactly cycle t+1, sender drops RTS at t+2. Max rate 1 flit / 2 cycles.
//  Read: read_en=1 && empty=0 -> rd_ptr++ at edge; Data_out shows new head next
//   cycle. read_en while empty: no state change (err handling per CONFIGURATION).
//  Pointers wrap modulo DEPTH; count tracks occupancy (width log2(DEPTH)+1);
//   empty=(count==0), full=(count==DEPTH), both registered/derived from count.
//  Simultaneous write+read (non-empty, non-full): both occur, count unchanged,
//   FIFO order preserved.
//  Full: RTS held high in IDLE gets no DCTS; after a pop at edge e, full=0 and
//   capture occurs at edge e+1 (DCTS high cycle after). Write and read never
//   collide on the same entry since write requires full=0 at decision time.
//  Read at count=1 with no write: empty=1 next cycle.
//  Reset mid-operation (incl. during ACK): DCTS drops immediately; any partly
//   acknowledged flit is discarded with the FIFO contents.
// CONFIGURATION
//  INPUT_FIFO_RX_ERR_EN defined: err set to 1 on any cycle with read_en=1 &&
//   empty=1; remains 1 until rst. Counters/pointers still unaffected.
//  Not defined: err tied to constant 0, no extra flop.
// TESTING
//  1 Reset: drive rst=0 mid-run -> DCTS=0, empty=1, full=0, err=0 same cycle.
//  2 Single flit: RTS=1, RX=32'hA5A5_0001 in cycle 0, held through cycle 1 ->
//    DCTS=1 only in cycle 1, empty=0, Data_out=32'hA5A5_0001, exactly 1 write.
//  3 Fill: 4 flits (1,2,3,4) with no reads -> full=1; 5th RTS held -> DCTS=0
//    until read_en pulse; flit 5 acked 2 cycles after pop; read order 1..5.
//  4 Concurrent: at count=2, write flit 7 and read_en=1 same edge -> count=2,
//    popped value is oldest entry, flit 7 read last.
//  5 Underflow: read_en=1 while empty -> ptrs unchanged, empty=1; with
//    INPUT_FIFO_RX_ERR_EN err=1 and stays 1; without it err=0.
//  6 Reset in ACK: assert rst=0 while DCTS=1 -> DCTS=0 immediately, empty=1;
//    after release, fresh RTS accepted with normal 1-cycle DCTS timing.

Source files
------------

// File: rtl/input_fifo_rx.sv
// Receiving end of the RTS/DCTS router link: captures flits into a show-ahead FIFO and pulses DCTS once per captured flit.
// Optional sticky read-underflow flag is enabled by defining INPUT_FIFO_RX_ERR_EN.
module input_fifo_rx #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] RX,
    input  logic                  RTS,
    output logic                  DCTS,
    input  logic                  read_en,
    output logic [DATA_WIDTH-1:0] Data_out,
    output logic                  empty,
    output logic                  full,
    output logic                  err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] ACK  = 1'b1;

    logic [0:0]            state;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  do_write;
    logic                  do_read;

    // RTS is only honoured in IDLE so a flit still held high during its ACK cycle is not captured twice.
    assign do_write = (state == IDLE) && RTS && !full;
    assign do_read  = read_en && !empty;

    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign Data_out = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            DCTS  <= 1'b0;
        end else begin
            state <= do_write ? ACK : IDLE;
            DCTS  <= do_write;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_read) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CNT_W'(do_write) - CNT_W'(do_read);
        end
    end

    // Storage is intentionally not reset; Data_out is meaningless while empty.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr] <= RX;
        end
    end

`ifdef INPUT_FIFO_RX_ERR_EN
    logic err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (read_en && empty) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_input_fifo_rx.sv
// Self-checking bench for input_fifo_rx: directed link scenarios plus a randomized
// protocol-following sender, all checked against a queue-based reference model.
module tb_input_fifo_rx;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
`ifdef INPUT_FIFO_RX_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic [DW-1:0] RX;
    logic          RTS;
    logic          DCTS;
    logic          read_en;
    logic [DW-1:0] Data_out;
    logic          empty;
    logic          full;
    logic          err;

    input_fifo_rx #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .RX       (RX),
        .RTS      (RTS),
        .DCTS     (DCTS),
        .read_en  (read_en),
        .Data_out (Data_out),
        .empty    (empty),
        .full     (full),
        .err      (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    // Reference model: FIFO contents, the DCTS expected this cycle, sticky error.
    logic [DW-1:0] q[$];
    bit            exp_dcts;
    bit            exp_err;

    task automatic checkOutput(input string tag, input logic [DW-1:0] observed, input logic [DW-1:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    // One clock: compare outputs mid-cycle, then advance the model across the rising edge.
    task automatic tick();
        bit            accept;
        bit            pop;
        bit            under;
        logic [DW-1:0] flit;
        @(negedge clk);
        checkOutput("dcts",  DW'(DCTS),  DW'(exp_dcts));
        checkOutput("empty", DW'(empty), DW'(q.size() == 0));
        checkOutput("full",  DW'(full),  DW'(q.size() == DEPTH));
        checkOutput("err",   DW'(err),   DW'(exp_err));
        if (q.size() > 0) checkOutput("data_out", Data_out, q[0]);
        accept = RTS && !exp_dcts && (q.size() < DEPTH);
        pop    = read_en && (q.size() > 0);
        under  = read_en && (q.size() == 0);
        flit   = RX;
        @(posedge clk);
        if (pop) void'(q.pop_front());
        if (accept) q.push_back(flit);
        exp_dcts = accept;
        if (under && ERR_EN) exp_err = 1'b1;
        #1;
    endtask

    task automatic applyStimulus(input bit rts, input logic [DW-1:0] data, input bit rd);
        RTS     = rts;
        RX      = data;
        read_en = rd;
        tick();
    endtask

    // Sender holds RTS for the capture cycle and the DCTS cycle, then drops it.
    task automatic sendFlit(input logic [DW-1:0] data);
        applyStimulus(1'b1, data, 1'b0);
        applyStimulus(1'b1, data, 1'b0);
    endtask

    // Asynchronous reset asserted away from the clock edge; outputs must clear immediately.
    task automatic doReset();
        RTS     = 1'b0;
        read_en = 1'b0;
        rst     = 1'b0;
        #2;
        checkOutput("rst_dcts",  DW'(DCTS),  '0);
        checkOutput("rst_empty", DW'(empty), DW'(1));
        checkOutput("rst_full",  DW'(full),  '0);
        checkOutput("rst_err",   DW'(err),   '0);
        q.delete();
        exp_dcts = 1'b0;
        exp_err  = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        bit drop_next;
        rst = 1'b0; RTS = 1'b0; RX = '0; read_en = 1'b0;
        exp_dcts = 1'b0; exp_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        doReset();

        // Single flit: DCTS exactly one cycle, one entry visible at the head.
        sendFlit(32'hA5A5_0001);
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("single_data", Data_out, 32'hA5A5_0001);
        checkOutput("single_count", DW'(q.size()), DW'(1));
        applyStimulus(1'b0, '0, 1'b1);

        // Fill, then hold a fifth flit while full until one pop frees space.
        for (int i = 1; i <= 4; i++) sendFlit(DW'(i));
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, DW'(5), 1'b0);
        checkOutput("full_hold_dcts", DW'(DCTS), '0);
        applyStimulus(1'b1, DW'(5), 1'b1);
        applyStimulus(1'b1, DW'(5), 1'b0);
        checkOutput("refill_dcts", DW'(DCTS), DW'(1));
        applyStimulus(1'b1, DW'(5), 1'b0);
        for (int i = 2; i <= 5; i++) begin
            checkOutput("fill_order", Data_out, DW'(i));
            applyStimulus(1'b0, '0, 1'b1);
        end

        // Concurrent write and read at count=2.
        sendFlit(32'h11);
        sendFlit(32'h22);
        applyStimulus(1'b1, 32'h7, 1'b1);
        applyStimulus(1'b1, 32'h7, 1'b0);
        checkOutput("conc_count", DW'(q.size()), DW'(2));
        checkOutput("conc_head", Data_out, 32'h22);
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("conc_last", Data_out, 32'h7);
        applyStimulus(1'b0, '0, 1'b1);

        // Underflow: reads while empty change nothing but the optional sticky flag.
        applyStimulus(1'b0, '0, 1'b1);
        applyStimulus(1'b0, '0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("under_err", DW'(err), DW'(ERR_EN));
        sendFlit(32'hBEEF);
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("under_data", Data_out, 32'hBEEF);

        // Reset during the ACK cycle discards the flit; a fresh flit gets normal timing.
        applyStimulus(1'b1, 32'hDEAD, 1'b0);
        checkOutput("ack_before_rst", DW'(DCTS), DW'(1));
        doReset();
        sendFlit(32'hCAFE_0006);
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("post_rst_data", Data_out, 32'hCAFE_0006);

        // Randomized traffic with phases of light and heavy draining.
        RTS = 1'b0;
        drop_next = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if (RTS && drop_next) begin
                RTS = 1'b0;
                drop_next = 1'b0;
            end else if (RTS && exp_dcts) begin
                drop_next = 1'b1;
            end else if (!RTS && ($urandom_range(0, 2) != 0)) begin
                RTS = 1'b1;
                RX  = $urandom;
            end
            read_en = ((i / 100) % 2 == 0) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 1) == 1);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
